vda_word_encoder: RTL and testbench

VDA_WORD_ENCODER -- requirements
Module: vda_word_encoder

---
 rtl/vda_word_encoder.sv | 130 +++++++++++++
 tb/tb_vda_word_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vda_word_encoder.sv
// Command FIFO feeding a repeating 17-bit word emitter for the VDA decoder.
// Each command {rpt, cond, op} is presented as {cond, op} rpt+1 times.
module vda_word_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_op,
    input  logic [10:0] cmd_cond,
    input  logic [1:0]  cmd_rpt,
    input  logic        flush,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [16:0] word,
    output logic [7:0]  word_cnt,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [18:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    state_t        state_q;
    logic [16:0]   word_q;
    logic [1:0]    rep_q;
    logic [7:0]    wcnt_q, wcnt_d;

    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        hs;
    logic [18:0] head;

    assign fifo_empty = (cnt_q == '0);
    assign cmd_ready  = (cnt_q != FULL);
    assign push       = cmd_valid & cmd_ready & ~flush;
    assign hs         = (state_q == SEND) & word_ready;
    // Pop on idle-with-data, or when the last repeat of the current word is taken.
    assign pop        = ~flush & ~fifo_empty &
                        ((state_q == IDLE) | (hs & (rep_q == 2'd0)));
    assign head       = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (hs && wcnt_q != 8'hFF) begin
            wcnt_d = wcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {cmd_rpt, cmd_cond, cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            word_q  <= '0;
            rep_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                cnt_q   <= '0;
                state_q <= IDLE;
                rep_q   <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) begin
                    wptr_q <= wptr_q + AW'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + AW'(1);
                end
                case (state_q)
                    IDLE: begin
                        if (pop) begin
                            word_q  <= head[16:0];
                            rep_q   <= head[18:17];
                            state_q <= SEND;
                        end
                    end
                    SEND: begin
                        if (word_ready) begin
                            if (rep_q != 2'd0) begin
                                rep_q <= rep_q - 2'd1;
                            end else if (pop) begin
                                word_q <= head[16:0];
                                rep_q  <= head[18:17];
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign word_valid = (state_q == SEND);
    assign word       = word_q;
    assign word_cnt   = wcnt_q;
    assign busy       = ~fifo_empty | word_valid;

endmodule

// File: tb/tb_vda_word_encoder.sv
// Bench for vda_word_encoder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vda_word_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [10:0] cmd_cond = '0;
    logic [1:0]  cmd_rpt = '0;
    logic        flush = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [16:0] word;
    logic [7:0]  word_cnt;
    logic        busy;

    int checks = 0;
    int failures = 0;

    vda_word_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_cond(cmd_cond),
        .cmd_rpt(cmd_rpt),
        .flush(flush),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word(word),
        .word_cnt(word_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands plus the word on display
    // and how many more times it must be shown.
    logic [18:0] mq[$];
    bit          m_valid = 0;
    logic [16:0] m_word = '0;
    int          m_rem = 0;
    int          m_cnt = 0;
    int          m_max = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        bit hs;
        bit do_push;
        bit do_pop;
        logic [18:0] e;
        if (!rst_n) begin
            mq.delete();
            m_valid = 0;
            m_word  = '0;
            m_rem   = 0;
            m_cnt   = 0;
        end else begin
            hs = m_valid && word_ready;
            if (hs && m_cnt < 255) m_cnt++;
            if (flush) begin
                mq.delete();
                m_valid = 0;
                m_rem   = 0;
            end else begin
                do_push = cmd_valid && (mq.size() != DEPTH);
                do_pop  = 0;
                if (!m_valid) begin
                    do_pop = (mq.size() > 0);
                end else if (hs) begin
                    if (m_rem > 0) m_rem--;
                    else if (mq.size() > 0) do_pop = 1;
                    else m_valid = 0;
                end
                if (do_pop) begin
                    e = mq.pop_front();
                    m_word  = e[16:0];
                    m_rem   = int'(e[18:17]);
                    m_valid = 1;
                end
                if (do_push) mq.push_back({cmd_rpt, cmd_cond, cmd_op});
            end
        end
        if (mq.size() > m_max) m_max = mq.size();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("word_valid", 32'(word_valid), 32'(m_valid));
            chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
            chk("busy", 32'(busy), 32'(m_valid || mq.size() != 0));
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            if (m_valid) chk("word", 32'(word), 32'(m_word));
        end
    end

    task automatic push_cmd(input logic [5:0] op, input logic [10:0] cond,
                            input logic [1:0] rpt);
        bit acc;
        acc = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cond  = cond;
        cmd_rpt   = rpt;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input logic v);
        int n;
        n = 0;
        while (word_valid !== v && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (word_valid !== v) chk("wait_valid_timeout", 32'(word_valid), 32'(v));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit pat[5];
        int c0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        @(negedge clk);
        do_reset();
        chk_en = 1;
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_word", 32'(word), 32'd0);

        // Single command, one word, two edges after accept
        word_ready = 1'b1;
        push_cmd(6'b011011, 11'd0, 2'd0);
        chk("single_not_yet", 32'(word_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(word_valid), 32'd1);
        chk("single_word", 32'(word), 32'h0001B);
        @(negedge clk);
        chk("single_gone", 32'(word_valid), 32'd0);
        chk("single_cnt", 32'(word_cnt), 32'd1);

        // Repeat with a stall in the middle
        push_cmd(6'h2A, 11'h5A5, 2'd3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            word_ready = pat[i];
            @(negedge clk);
        end
        chk("rpt_cnt", 32'(word_cnt), 32'd5);
        chk("rpt_idle", 32'(word_valid), 32'd0);

        // Back-pressure: fill output register plus FIFO, then stall
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(6'(i + 1), 11'(i * 3), 2'd0);
        cmd_valid = 1'b1;
        cmd_op = 6'h3F;
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        word_ready = 1'b1;
        c0 = int'(word_cnt);
        for (int i = 0; i < 5; i++) begin
            chk("bp_no_gap", 32'(word_valid), 32'd1);
            chk("bp_order", 32'(word[5:0]), 32'(i + 1));
            @(negedge clk);
        end
        chk("bp_drained", 32'(word_cnt), 32'(c0 + 5));
        chk("bp_idle", 32'(word_valid), 32'd0);

        // Streaming across pointer wrap
        m_max = 0;
        for (int i = 0; i < 10; i++) push_cmd(6'(i), 11'(i * 7 + 1), 2'd0);
        wait_valid(1'b0);
        chk("wrap_max_fill", 32'(m_max <= 2), 32'd1);

        // Flush mid-stream
        word_ready = 1'b0;
        push_cmd(6'h11, 11'h111, 2'd2);
        for (int i = 0; i < 3; i++) push_cmd(6'(i + 20), 11'h0F0, 2'd1);
        c0 = int'(word_cnt);
        chk("fl_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", 32'(word_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_cnt", 32'(word_cnt), 32'(c0));
        chk("fl_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        chk("fl_stays_idle", 32'(word_valid), 32'd0);

        // Saturation then reset while sending
        word_ready = 1'b1;
        for (int i = 0; i < 70; i++) push_cmd(6'(i), 11'(i), 2'd3);
        chk("sat_cnt", 32'(word_cnt), 32'd255);
        wait_valid(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_valid", 32'(word_valid), 32'd0);
        chk("rst2_cnt", 32'(word_cnt), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_word", 32'(word), 32'd0);
        chk("rst2_ready", 32'(cmd_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cmd_valid  = ($urandom_range(0, 9) < 6);
            cmd_op     = 6'($urandom);
            cmd_cond   = 11'($urandom);
            cmd_rpt    = 2'($urandom);
            word_ready = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("end_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
